// File: rtl/debounce_pkg.sv
// debounce_pkg: debounce FSM state encoding and counter-width helper shared by the bank.
package debounce_pkg;
   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      WAIT_HIGH   = 2'd1,
      STABLE_HIGH = 2'd2,
      WAIT_LOW    = 2'd3
   } state_e;
   function automatic int count_w(input int max_val);
      return $clog2(max_val + 1);
   endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: 2-flop synchroniser, 4-state debounce FSM and terminal counter for one input.
// Long-press counter present only when DEBOUNCE_LONG_PRESS_EN is defined.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int COUNT_MAX   = 700,
   parameter int LONG_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic long_o
);
   localparam int CW = count_w(COUNT_MAX);
   if (COUNT_MAX < 2) begin : g_bad_count
      $error("debounce_channel: COUNT_MAX must be at least 2");
   end
   if (LONG_CYCLES < 2) begin : g_bad_long
      $error("debounce_channel: LONG_CYCLES must be at least 2");
   end
   logic          sync1_q, s_q;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d, rise_q, rise_d, fall_q, fall_d;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         s_q     <= 1'b0;
         state_q <= STABLE_LOW;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= sig_i;
         s_q     <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end
   // Any sample disagreeing with the pending level drops back to the stable state, so the count restarts
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         STABLE_LOW: if (s_q) begin
            state_d = WAIT_HIGH;
            cnt_d   = '0;
         end
         WAIT_HIGH: if (!s_q) state_d = STABLE_LOW;
            else if (cnt_q == CW'(COUNT_MAX - 1)) begin
               state_d = STABLE_HIGH;
               level_d = 1'b1;
               rise_d  = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
         STABLE_HIGH: if (!s_q) begin
            state_d = WAIT_LOW;
            cnt_d   = '0;
         end
         WAIT_LOW: if (s_q) state_d = STABLE_HIGH;
            else if (cnt_q == CW'(COUNT_MAX - 1)) begin
               state_d = STABLE_LOW;
               level_d = 1'b0;
               fall_d  = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
         default: state_d = STABLE_LOW;
      endcase
   end
   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
`ifdef DEBOUNCE_LONG_PRESS_EN
   localparam int LW = count_w(LONG_CYCLES);
   logic [LW-1:0] lcnt_q, lcnt_d;
   logic          long_q, long_d;
   // Counter parks at LONG_CYCLES so the strobe fires once per press
   always_comb begin
      lcnt_d = '0;
      long_d = 1'b0;
      if (state_q == STABLE_HIGH && s_q) begin
         lcnt_d = (lcnt_q == LW'(LONG_CYCLES)) ? lcnt_q : lcnt_q + 1'b1;
         long_d = lcnt_q == LW'(LONG_CYCLES - 1);
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lcnt_q <= '0;
         long_q <= 1'b0;
      end else begin
         lcnt_q <= lcnt_d;
         long_q <= long_d;
      end
   end
   assign long_o = long_q;
`else
   assign long_o = 1'b0;
`endif
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: CHANNELS independent debouncers with level, rise/fall strobes and optional
// long-press strobe (enabled by defining DEBOUNCE_LONG_PRESS_EN).
module debounce_bank #(
   parameter int CHANNELS         = 4,
   parameter int CLK_FREQ_HZ      = 100000,
   parameter int DEBOUNCE_TIME_MS = 7,
   parameter int LONG_PRESS_MS    = 1000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] signal_in,
   output logic [CHANNELS-1:0] signal_out,
   output logic [CHANNELS-1:0] rise_pulse,
   output logic [CHANNELS-1:0] fall_pulse,
   output logic [CHANNELS-1:0] long_press
);
   localparam int COUNT_MAX   = CLK_FREQ_HZ * DEBOUNCE_TIME_MS / 1000;
   localparam int LONG_CYCLES = CLK_FREQ_HZ * LONG_PRESS_MS / 1000;
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
         .COUNT_MAX  (COUNT_MAX),
         .LONG_CYCLES(LONG_CYCLES)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .sig_i  (signal_in[i]),
         .level_o(signal_out[i]),
         .rise_o (rise_pulse[i]),
         .fall_o (fall_pulse[i]),
         .long_o (long_press[i])
      );
   end
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed and random stimulus against a run-length reference model of the debouncer.
module tb_debounce_bank;
   localparam int CH = 4, FREQ = 100000, DMS = 1, LMS = 5;
   localparam int CMAX = FREQ * DMS / 1000;
   localparam int LONG = FREQ * LMS / 1000;
   logic clk = 1'b0, rst = 1'b0;
   logic [CH-1:0] signal_in = '0, signal_out, rise_pulse, fall_pulse, long_press;
   int vectors = 0, miscompares = 0, rise1 = 0, long0 = 0;
   bit [CH-1:0] sa, sb, lvl, settled, er, ef, el;
   int run [CH];
   int held [CH];
   debounce_bank #(
      .CHANNELS(CH), .CLK_FREQ_HZ(FREQ), .DEBOUNCE_TIME_MS(DMS), .LONG_PRESS_MS(LMS)
   ) dut (
      .clk(clk), .rst(rst), .signal_in(signal_in), .signal_out(signal_out),
      .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .long_press(long_press)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // Model: the synchronised sample lags the pin by two edges; the level flips once the sample has
   // disagreed with it for CMAX+1 consecutive edges; long press fires LONG edges into a settled high.
   always @(posedge clk) begin
      er = '0;
      ef = '0;
      el = '0;
      if (!rst) begin
         sa = '0;
         sb = '0;
         lvl = '0;
         settled = '0;
         for (int c = 0; c < CH; c++) begin
            run[c] = 0;
            held[c] = 0;
         end
      end else begin
         for (int c = 0; c < CH; c++) begin
            bit s;
            s = sb[c];
            sb[c] = sa[c];
            sa[c] = signal_in[c];
            run[c] = (s != lvl[c]) ? run[c] + 1 : 0;
            if (run[c] == CMAX + 1) begin
               lvl[c] = s;
               run[c] = 0;
               if (s) er[c] = 1'b1;
               else ef[c] = 1'b1;
            end
            if (lvl[c] && s && settled[c]) begin
               if (held[c] == LONG - 1) el[c] = 1'b1;
               if (held[c] < LONG) held[c]++;
            end else held[c] = 0;
            settled[c] = lvl[c] && s;
         end
      end
`ifndef DEBOUNCE_LONG_PRESS_EN
      el = '0;
`endif
      #1;
      chk("signal_out", 32'(signal_out), 32'(lvl));
      chk("rise_pulse", 32'(rise_pulse), 32'(er));
      chk("fall_pulse", 32'(fall_pulse), 32'(ef));
      chk("long_press", 32'(long_press), 32'(el));
      chk("rise_fall_exclusive", 32'(rise_pulse & fall_pulse), 32'd0);
      if (rise_pulse[1]) rise1++;
      if (long_press[0]) long0++;
   end
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask
   // Call right after an input change on a falling edge: the next rising edge is edge 0
   task automatic wait_edge(input int c, input bit rise, input string name);
      int n = 0;
      bit seen = 1'b0;
      @(posedge clk);
      while (!seen && n < 400) begin
         @(posedge clk);
         n++;
         #2;
         seen = rise ? rise_pulse[c] : fall_pulse[c];
      end
      chk(name, seen ? 32'(n) : 32'hFFFF_FFFF, 32'd102);
   endtask
   task automatic wait_pair(input bit rise, input string name);
      int n = 0;
      logic [1:0] v = 2'b00;
      while (v == 2'b00 && n < 400) begin
         @(posedge clk);
         n++;
         #2;
         v = rise ? rise_pulse[3:2] : fall_pulse[3:2];
      end
      chk(name, 32'(v), 32'd3);
   endtask
   initial begin
      int r0, l0, n;
      int hold [CH];
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         signal_in = 4'($urandom);
      end
      #1;
      chk("reset_outputs", 32'({signal_out, rise_pulse, fall_pulse, long_press}), 32'd0);
      @(negedge clk);
      signal_in = '0;
      rst = 1'b1;
      step(300);
      chk("idle_level", 32'(signal_out), 32'd0);
      signal_in[0] = 1'b1;
      wait_edge(0, 1'b1, "ch0_rise_latency");
      chk("ch0_only_rise", 32'(rise_pulse), 32'd1);
      chk("ch0_only_level", 32'(signal_out), 32'd1);
      step(100);
      signal_in[0] = 1'b0;
      wait_edge(0, 1'b0, "ch0_fall_latency");
      step(10);
      r0 = rise1;
      signal_in[1] = 1'b1;
      step(80);
      signal_in[1] = 1'b0;
      step(20);
      signal_in[1] = 1'b1;
      step(90);
      signal_in[1] = 1'b0;
      step(10);
      signal_in[1] = 1'b1;
      wait_edge(1, 1'b1, "bounce_rise_latency");
      step(900);
      chk("bounce_single_rise", 32'(rise1 - r0), 32'd1);
      signal_in[1] = 1'b0;
      step(200);
      signal_in[3:2] = 2'b11;
      wait_pair(1'b1, "pair_rise");
      step(200);
      signal_in[3:2] = 2'b00;
      wait_pair(1'b0, "pair_fall");
      step(10);
      signal_in[0] = 1'b1;
      step(52);
      rst = 1'b0;
      #1;
      chk("reset_mid_wait", 32'({signal_out, rise_pulse, fall_pulse, long_press}), 32'd0);
      step(3);
      rst = 1'b1;
      l0 = long0;
      wait_edge(0, 1'b1, "rst_release_rise");
`ifdef DEBOUNCE_LONG_PRESS_EN
      n = 0;
      while (!long_press[0] && n < 700) begin
         @(posedge clk);
         n++;
         #2;
      end
      chk("long_press_latency", long_press[0] ? 32'(n) : 32'hFFFF_FFFF, 32'd500);
      step(700);
      chk("long_press_once", 32'(long0 - l0), 32'd1);
`else
      n = 0;
      step(1200);
      chk("long_press_absent", 32'(long0 - l0 + n), 32'd0);
`endif
      signal_in[0] = 1'b0;
      step(200);
      for (int c = 0; c < CH; c++) hold[c] = $urandom_range(1, 40);
      for (int t = 0; t < 6000; t++) begin
         @(negedge clk);
         if (t == 3000) rst = 1'b0;
         if (t == 3003) rst = 1'b1;
         for (int c = 0; c < CH; c++) begin
            hold[c]--;
            if (hold[c] == 0) begin
               signal_in[c] = ~signal_in[c];
               hold[c] = $urandom_range(0, 1) ? $urandom_range(1, 40) : $urandom_range(95, 140);
            end
         end
      end
      step(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
